stash_command_arbiter: RTL
==========================

# stash_command_arbiter

Shares the single command/data port of the stash core between two requesters: requester 0 (path-read engine pushing tree blocks) and requester 1 (frontend issuing peak/overwrite/dump/sync). Arbitrates round-robin, forwards the granted requester's command fields, then locks the grant through the full data burst of data-carrying commands. Sits directly in front of the stash core command and data inputs.

## Interface
- DataWidth, 512, data beat width
- CMDWidth, 3, command code width; codes come from the shared stash constants header
- ORAMU, 32, program address width
- ORAML, 32, leaf width
- StashEAWidth, 8, stash entry address width
- BlockBeats, 4, data beats per Push/Overwrite command (>=1)

- Clock  in  1  sole clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- Req0Command / Req1Command  in  CMDWidth  requested command
- Req0PAddr / Req1PAddr  in  ORAMU  program address
- Req0Leaf / Req1Leaf  in  ORAML  leaf
- Req0SAddr / Req1SAddr  in  StashEAWidth  stash entry address
- Req0CommandValid / Req1CommandValid  in  1  command request
- Req0CommandReady / Req1CommandReady  out  1  command accepted this cycle
- Req0Data / Req1Data  in  DataWidth  data beat
- Req0DataValid / Req1DataValid  in  1  beat valid
- Req0DataReady / Req1DataReady  out  1  beat accepted this cycle
- OutCommand, OutPAddr, OutLeaf, OutSAddr  out  CMDWidth/ORAMU/ORAML/StashEAWidth  to stash core
- OutCommandValid  out  1;  OutCommandReady  in  1
- OutData  out  DataWidth;  OutValid  out  1;  OutReady  in  1
- OutGrant  out  1  current/last granted requester index
- OutBusy  out  1  high in CMD or DATA state

## Operation
- States: IDLE, CMD, DATA. Registers: state, Grant (1b), LastGrant (1b), BeatCount (clog2(BlockBeats)+1 b).
- IDLE: if exactly one ReqNCommandValid, Grant<=N; if both, Grant<=~LastGrant; go to CMD. No request: stay.
- CMD: OutCommandValid=1; OutCommand/PAddr/Leaf/SAddr = granted requester's inputs (combinational mux). ReqNCommandReady = (Grant==N) & OutCommandReady. On accept: LastGrant<=Grant; if command is CMD_Push or CMD_Overwrite -> DATA with BeatCount<=0, else -> IDLE.
- DATA: OutData/OutValid = granted requester's Data/DataValid; ReqNDataReady = (Grant==N) & OutReady. Each OutValid&OutReady increments BeatCount; beat BlockBeats-1 accepted -> IDLE.
- Non-granted requester: CommandReady=0, DataReady=0 always. Requesters hold command fields stable while Valid and not Ready.
- OutCommandValid=0 outside CMD; OutValid=0 outside DATA. OutData/command fields don't-care when their valid is low.
- Requester dropping CommandValid in CMD is illegal (protocol violation; no recovery required).

## Timing
- Reset: state=IDLE, Grant=0, LastGrant=1 (requester 0 wins first tie), BeatCount=0; all Ready/Valid outputs 0, OutBusy=0, OutGrant=0.
- Arbitration latency: request seen in IDLE at cycle t -> OutCommandValid at t+1.
- CMD->IDLE->CMD: one bubble cycle between back-to-back commands.
- Data beats: zero added latency, one beat/cycle max; stalls follow OutReady and granted DataValid.
- Reset mid-CMD or mid-DATA: next cycle IDLE with reset values; partial burst abandoned, BeatCount cleared.
- BlockBeats=1: DATA lasts exactly one accepted beat.

## Configuration
- STASH_ARB_FIXED_PRIORITY_EN: when defined, IDLE tie always grants requester 0 (path-read priority); LastGrant unused. When undefined, round-robin as above.

## Test plan
- Single Push from req0 (PAddr 0xf0000000, Leaf 0x0000ffff), BlockBeats=4 -> OutCommandValid one cycle after request, four beats forwarded, Req1 never Ready, OutBusy falls after beat 3.
- Both requesters valid from reset: req0 Push, req1 Peak SAddr 1 -> req0 granted first, then req1 Peak issued after req0 burst completes; next tie grants req0 again.
- Req1 Dump with OutCommandReady held low 5 cycles -> OutCommandValid held, fields stable, returns to IDLE same edge as accept, no DATA state.
- Overwrite (PAddr 0xba5eba11, SAddr 1) with OutReady toggling every other cycle -> exactly 4 beats, BeatCount only advances on OutValid&OutReady.
- Reset asserted after beat 2 of a Push -> next cycle IDLE, all outputs 0, new Push completes full 4 beats.
- With STASH_ARB_FIXED_PRIORITY_EN, both requesters continuously pushing -> req0 wins every tie.

Source files
------------

// File: rtl/stash_command_arbiter.sv
// rtl/stash_command_arbiter.sv - two-requester round-robin arbiter for the stash core command/data port
// Define STASH_ARB_FIXED_PRIORITY_EN to make requester 0 win every tie instead of alternating.

module stash_command_arbiter #(
  parameter int DataWidth    = 512,
  parameter int CMDWidth     = 3,
  parameter int ORAMU        = 32,
  parameter int ORAML        = 32,
  parameter int StashEAWidth = 8,
  parameter int BlockBeats   = 4,
  parameter logic [CMDWidth-1:0] CMD_Push      = CMDWidth'(0),
  parameter logic [CMDWidth-1:0] CMD_Overwrite = CMDWidth'(2)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [CMDWidth-1:0]     Req0Command,
  input  logic [ORAMU-1:0]        Req0PAddr,
  input  logic [ORAML-1:0]        Req0Leaf,
  input  logic [StashEAWidth-1:0] Req0SAddr,
  input  logic                    Req0CommandValid,
  output logic                    Req0CommandReady,
  input  logic [DataWidth-1:0]    Req0Data,
  input  logic                    Req0DataValid,
  output logic                    Req0DataReady,
  input  logic [CMDWidth-1:0]     Req1Command,
  input  logic [ORAMU-1:0]        Req1PAddr,
  input  logic [ORAML-1:0]        Req1Leaf,
  input  logic [StashEAWidth-1:0] Req1SAddr,
  input  logic                    Req1CommandValid,
  output logic                    Req1CommandReady,
  input  logic [DataWidth-1:0]    Req1Data,
  input  logic                    Req1DataValid,
  output logic                    Req1DataReady,
  output logic [CMDWidth-1:0]     OutCommand,
  output logic [ORAMU-1:0]        OutPAddr,
  output logic [ORAML-1:0]        OutLeaf,
  output logic [StashEAWidth-1:0] OutSAddr,
  output logic                    OutCommandValid,
  input  logic                    OutCommandReady,
  output logic [DataWidth-1:0]    OutData,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic                    OutGrant,
  output logic                    OutBusy
);

  localparam int BCW = $clog2(BlockBeats) + 1;
  localparam logic [BCW-1:0] LastBeat = BCW'(BlockBeats - 1);

  typedef enum logic [1:0] {StIdle, StCmd, StData} state_t;

  state_t         state, nextState;
  logic           grant, nextGrant;
  logic [BCW-1:0] beatCount, nextBeatCount;
  logic           tieGrant;
  logic           isDataCmd;

`ifdef STASH_ARB_FIXED_PRIORITY_EN
  assign tieGrant = 1'b0;
`else
  logic lastGrant, nextLastGrant;
  assign tieGrant = ~lastGrant;
`endif

  // Command fields are steered straight from the granted requester; only valids are state-gated.
  assign OutCommand = grant ? Req1Command : Req0Command;
  assign OutPAddr   = grant ? Req1PAddr   : Req0PAddr;
  assign OutLeaf    = grant ? Req1Leaf    : Req0Leaf;
  assign OutSAddr   = grant ? Req1SAddr   : Req0SAddr;
  assign OutData    = grant ? Req1Data    : Req0Data;
  assign OutGrant   = grant;
  assign OutBusy    = (state != StIdle);
  assign isDataCmd  = (OutCommand == CMD_Push) || (OutCommand == CMD_Overwrite);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= StIdle;
      grant     <= 1'b0;
      beatCount <= '0;
`ifndef STASH_ARB_FIXED_PRIORITY_EN
      lastGrant <= 1'b1;
`endif
    end else begin
      state     <= nextState;
      grant     <= nextGrant;
      beatCount <= nextBeatCount;
`ifndef STASH_ARB_FIXED_PRIORITY_EN
      lastGrant <= nextLastGrant;
`endif
    end
  end

  always_comb begin
    nextState        = state;
    nextGrant        = grant;
    nextBeatCount    = beatCount;
`ifndef STASH_ARB_FIXED_PRIORITY_EN
    nextLastGrant    = lastGrant;
`endif
    OutCommandValid  = 1'b0;
    OutValid         = 1'b0;
    Req0CommandReady = 1'b0;
    Req1CommandReady = 1'b0;
    Req0DataReady    = 1'b0;
    Req1DataReady    = 1'b0;

    case (state)
      StIdle: begin
        if (Req0CommandValid || Req1CommandValid) begin
          nextState = StCmd;
          nextGrant = (Req0CommandValid && Req1CommandValid) ? tieGrant : Req1CommandValid;
        end
      end
      StCmd: begin
        OutCommandValid  = 1'b1;
        Req0CommandReady = ~grant & OutCommandReady;
        Req1CommandReady =  grant & OutCommandReady;
        if (OutCommandReady) begin
`ifndef STASH_ARB_FIXED_PRIORITY_EN
          nextLastGrant = grant;
`endif
          if (isDataCmd) begin
            nextState     = StData;
            nextBeatCount = '0;
          end else begin
            nextState = StIdle;
          end
        end
      end
      StData: begin
        OutValid      = grant ? Req1DataValid : Req0DataValid;
        Req0DataReady = ~grant & OutReady;
        Req1DataReady =  grant & OutReady;
        // The grant stays locked until the final beat of the burst is taken.
        if (OutValid && OutReady) begin
          nextBeatCount = beatCount + BCW'(1);
          if (beatCount == LastBeat) begin
            nextState = StIdle;
          end
        end
      end
      default: nextState = StIdle;
    endcase
  end

endmodule
